// File: rtl/mem_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_sched_if
// Purpose  : Bundles the instruction port, data port and RAM port of the
//            memory scheduler. The slave modport is the scheduler's view; the
//            master modport is the view of the requesters and the RAM model.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_sched_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : mem_sched
// Purpose  : Arbitrates one shared RAM between an instruction fetch port and
//            a data port. Data has priority, but after DMAX consecutive data
//            grants with a fetch pending the fetch is forced through. Each
//            access is bounded by a TIMEOUT-cycle watchdog with a sticky err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_sched #(
  parameter int DMAX    = 4,
  parameter int TIMEOUT = 15
) (
  input  wire logic  CLK,
  input  wire logic  RST,
  mem_sched_if.slave bus
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_IACC = 2'd1;
  localparam logic [1:0] c_DACC = 2'd2;

  localparam int c_SW = $clog2(DMAX + 1);
  localparam int c_TW = $clog2(TIMEOUT + 1);
  localparam logic [c_SW-1:0] c_DMAX_V    = c_SW'(DMAX);
  localparam logic [c_TW-1:0] c_TIMEOUT_V = c_TW'(TIMEOUT);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_SW-1:0] r_starve;
  logic [c_TW-1:0] r_tcnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_store;
  logic            r_wr;
  logic            r_err;

  logic w_idle;
  logic w_access;
  logic w_dreq;
  logic w_grant_i;
  logic w_grant_d;
  logic w_timeout;

  assign w_idle    = (r_state == c_IDLE);
  assign w_access  = !w_idle;
  assign w_dreq    = bus.dREN | bus.dWEN;
  // The fetch wins when nothing else wants the RAM, or when it has been starved.
  assign w_grant_i = w_idle & bus.iREN & (!w_dreq | (r_starve == c_DMAX_V));
  assign w_grant_d = w_idle & w_dreq & !w_grant_i;
  // A completion arriving in the last allowed cycle still counts as success.
  assign w_timeout = w_access & !bus.ramready & (r_tcnt == c_TIMEOUT_V);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Next-state: grant from IDLE, return to IDLE on completion or timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_grant_i)      w_next = c_IACC;
        else if (w_grant_d) w_next = c_DACC;
      end
      c_IACC, c_DACC: begin
        if (bus.ramready || w_timeout) w_next = c_IDLE;
      end
      default: w_next = c_IDLE;
    endcase
  end

  // Grant-time latching, starvation counting, watchdog and sticky error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_starve <= '0;
      r_tcnt   <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_grant_i) begin
        r_addr   <= bus.iaddr;
        r_store  <= '0;
        r_wr     <= 1'b0;
        r_starve <= '0;
        r_tcnt   <= '0;
      end else if (w_grant_d) begin
        r_addr  <= bus.daddr;
        r_store <= bus.dstore;
        r_wr    <= bus.dWEN;
        r_tcnt  <= '0;
        if (!bus.iREN)                r_starve <= '0;
        else if (r_starve != c_DMAX_V) r_starve <= r_starve + 1'b1;
      end else if (w_access && !bus.ramready && (r_tcnt != c_TIMEOUT_V)) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  // Outputs: RAM strobes from latched state only, requester status/data.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = w_dreq;
    bus.err      = r_err;
    case (r_state)
      c_IACC: begin
        bus.ramREN   = 1'b1;
        bus.ramaddr  = r_addr;
        bus.ramstore = r_store;
        if (bus.ramready) begin
          bus.iwait = 1'b0;
          bus.iload = bus.ramload;
        end else if (w_timeout) begin
          bus.iwait = 1'b0;
          bus.iload = 32'hFFFF_FFFF;
        end
      end
      c_DACC: begin
        bus.ramREN   = !r_wr;
        bus.ramWEN   = r_wr;
        bus.ramaddr  = r_addr;
        bus.ramstore = r_store;
        if (bus.ramready) begin
          bus.dwait = 1'b0;
          bus.dload = bus.ramload;
        end else if (w_timeout) begin
          bus.dwait = 1'b0;
          bus.dload = 32'hFFFF_FFFF;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_sched
// Purpose  : Self-checking bench for mem_sched: a cycle-by-cycle vector table
//            for fetch, contention, write precedence, reads, dropped requests
//            and stray ramready, plus sequences for starvation, timeout and
//            reset in the middle of an access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sched;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_sched_if bus ();

  mem_sched #(.DMAX(4), .TIMEOUT(15)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds, rl;
    logic        rr;
    logic        e_ren, e_wen;
    logic [31:0] e_ra, e_rs;
    logic        e_iw, e_dw;
    logic [31:0] e_il, e_dl;
    logic        e_err;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, ds, rl,
                              input logic rr, e_ren, e_wen, input logic [31:0] e_ra, e_rs,
                              input logic e_iw, e_dw, input logic [31:0] e_il, e_dl,
                              input logic e_err);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds; v.rl = rl; v.rr = rr;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_ra = e_ra; v.e_rs = e_rs;
    v.e_iw = e_iw; v.e_dw = e_dw; v.e_il = e_il; v.e_dl = e_dl; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input logic ir, dr, dw, input logic [31:0] ia, da, ds, rl, input logic rr);
    bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds;
    bus.ramload = rl; bus.ramready = rr;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  initial begin
    int dcount;
    int rounds;
    int round_d [2];

    // ir dr dw  ia  da  ds  rl  rr | ren wen ra rs iw dw il dl err
    vt.push_back(mk(0,0,0, 0,0,0,0,0,            0,0,0,0,0,0,0,0,0));           // reset state
    vt.push_back(mk(1,0,0, 32'h8,0,0,0,0,        0,0,0,0,1,0,0,0,0));           // fetch request, IDLE
    vt.push_back(mk(1,0,0, 32'h8,0,0,0,0,        1,0,32'h8,0,1,0,0,0,0));       // IACC cycle 1
    vt.push_back(mk(1,0,0, 32'h8,0,0,0,0,        1,0,32'h8,0,1,0,0,0,0));       // IACC cycle 2
    vt.push_back(mk(1,0,0, 32'h8,0,0,32'h8C430003,1, 1,0,32'h8,0,0,0,32'h8C430003,0,0)); // completion
    vt.push_back(mk(0,0,0, 0,0,0,0,0,            0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,1, 32'h10,32'h40,32'hAC240003,0,0, 0,0,0,0,1,1,0,0,0)); // contention
    vt.push_back(mk(1,0,1, 32'h10,32'h40,32'hAC240003,0,0, 0,1,32'h40,32'hAC240003,1,1,0,0,0));
    vt.push_back(mk(1,0,1, 32'h10,32'h40,32'hAC240003,32'h12345678,1, 0,1,32'h40,32'hAC240003,1,0,0,32'h12345678,0));
    vt.push_back(mk(1,0,0, 32'h10,32'h40,32'hAC240003,0,0, 0,0,0,0,1,0,0,0,0)); // IDLE bubble
    vt.push_back(mk(1,0,0, 32'h10,32'h40,32'hAC240003,0,0, 1,0,32'h10,0,1,0,0,0,0));
    vt.push_back(mk(1,0,0, 32'h10,0,0,32'hDEADBEEF,1, 1,0,32'h10,0,0,0,32'hDEADBEEF,0,0));
    vt.push_back(mk(0,0,0, 0,0,0,32'h55,1,       0,0,0,0,0,0,0,0,0));           // stray ramready
    vt.push_back(mk(0,0,0, 0,0,0,0,0,            0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,1, 0,32'h44,32'h1,0,0,   0,0,0,0,0,1,0,0,0));           // read+write: write wins
    vt.push_back(mk(0,1,1, 0,32'h44,32'h1,0,0,   0,1,32'h44,32'h1,0,1,0,0,0));
    vt.push_back(mk(0,1,1, 0,32'h44,32'h1,0,1,   0,1,32'h44,32'h1,0,0,0,0,0));
    vt.push_back(mk(0,0,0, 0,0,0,0,0,            0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(0,1,0, 0,32'h80,0,0,0,       0,0,0,0,0,1,0,0,0));           // data read
    vt.push_back(mk(0,1,0, 0,32'h80,0,0,0,       1,0,32'h80,0,0,1,0,0,0));
    vt.push_back(mk(0,1,0, 0,32'h80,0,32'hCAFEF00D,1, 1,0,32'h80,0,0,0,0,32'hCAFEF00D,0));
    vt.push_back(mk(0,0,0, 0,0,0,0,0,            0,0,0,0,0,0,0,0,0));
    vt.push_back(mk(1,0,0, 32'h20,0,0,0,0,       0,0,0,0,1,0,0,0,0));           // fetch, then dropped
    vt.push_back(mk(0,0,0, 32'h20,0,0,0,0,       1,0,32'h20,0,0,0,0,0,0));
    vt.push_back(mk(0,0,0, 32'h20,0,0,32'h77,1,  1,0,32'h20,0,0,0,32'h77,0,0));
    vt.push_back(mk(0,0,0, 0,0,0,0,0,            0,0,0,0,0,0,0,0,0));

    do_reset();

    foreach (vt[i]) begin
      drive(vt[i].ir, vt[i].dr, vt[i].dw, vt[i].ia, vt[i].da, vt[i].ds, vt[i].rl, vt[i].rr);
      #2;
      chk($sformatf("v%0d.ramREN", i),   32'(bus.ramREN),   32'(vt[i].e_ren));
      chk($sformatf("v%0d.ramWEN", i),   32'(bus.ramWEN),   32'(vt[i].e_wen));
      chk($sformatf("v%0d.ramaddr", i),  bus.ramaddr,       vt[i].e_ra);
      chk($sformatf("v%0d.ramstore", i), bus.ramstore,      vt[i].e_rs);
      chk($sformatf("v%0d.iwait", i),    32'(bus.iwait),    32'(vt[i].e_iw));
      chk($sformatf("v%0d.dwait", i),    32'(bus.dwait),    32'(vt[i].e_dw));
      chk($sformatf("v%0d.iload", i),    bus.iload,         vt[i].e_il);
      chk($sformatf("v%0d.dload", i),    bus.dload,         vt[i].e_dl);
      chk($sformatf("v%0d.err", i),      32'(bus.err),      32'(vt[i].e_err));
      next_cycle();
    end

    // Starvation: data held with fetch pending; RAM completes in one cycle.
    do_reset();
    drive(1, 1, 0, 32'h100, 32'h200, 0, 0, 0);
    dcount = 0;
    rounds = 0;
    round_d[0] = 0;
    round_d[1] = 0;
    for (int cyc = 0; cyc < 200 && rounds < 2; cyc++) begin
      bus.ramready = bus.ramREN;
      #1;
      if (bus.ramREN) begin
        if (bus.ramaddr == 32'h200) begin
          dcount++;
        end else if (bus.ramaddr == 32'h100) begin
          round_d[rounds] = dcount;
          dcount = 0;
          rounds++;
        end
      end
      next_cycle();
    end
    chk("starve_rounds_seen", 32'(rounds), 32'd2);
    chk("starve_dgrants_round0", 32'(round_d[0]), 32'd4);
    chk("starve_dgrants_round1", 32'(round_d[1]), 32'd4);

    // Timeout: read that the RAM never answers.
    do_reset();
    drive(0, 1, 0, 0, 32'h300, 0, 0, 0);
    #1;
    chk("to_idle_dwait", 32'(bus.dwait), 32'd1);
    next_cycle();
    for (int k = 1; k <= 16; k++) begin
      #1;
      chk($sformatf("to_c%0d.ramREN", k), 32'(bus.ramREN), 32'd1);
      chk($sformatf("to_c%0d.dwait", k),  32'(bus.dwait),  (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("to_c%0d.dload", k),  bus.dload,       (k < 16) ? 32'h0 : 32'hFFFF_FFFF);
      chk($sformatf("to_c%0d.err", k),    32'(bus.err),    32'd0);
      next_cycle();
    end
    bus.dREN = 1'b0;
    #1;
    chk("to_after.ramREN", 32'(bus.ramREN), 32'd0);
    chk("to_after.err", 32'(bus.err), 32'd1);
    repeat (5) next_cycle();
    chk("to_sticky.err", 32'(bus.err), 32'd1);
    do_reset();
    #1;
    chk("to_reset.err", 32'(bus.err), 32'd0);

    // Reset in the middle of a fetch, with a stale ramready right after.
    drive(1, 0, 0, 32'h400, 0, 0, 0, 0);
    next_cycle();
    #1;
    chk("rst_mid.ramREN_before", 32'(bus.ramREN), 32'd1);
    chk("rst_mid.ramaddr_before", bus.ramaddr, 32'h400);
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    drive(0, 0, 0, 32'h400, 0, 0, 32'h99, 1);
    #1;
    chk("rst_mid.ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_mid.ramaddr", bus.ramaddr, 32'h0);
    chk("rst_mid.err", 32'(bus.err), 32'd0);
    chk("rst_mid.iwait", 32'(bus.iwait), 32'd0);
    chk("rst_mid.iload", bus.iload, 32'h0);
    next_cycle();
    drive(1, 0, 0, 32'h400, 0, 0, 0, 0);
    #1;
    chk("rst_stale.ramREN", 32'(bus.ramREN), 32'd0);
    chk("rst_stale.iwait", 32'(bus.iwait), 32'd1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 Parameter DMAX, default 4: maximum consecutive data grants while an instruction request is pending.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles an access may wait for ramready.
REQ-003 Port CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Port RST  in  1  reset, synchronous, active-high.
REQ-005 Port iREN  in  1  instruction fetch request.
REQ-006 Port iaddr  in  32  instruction word address.
REQ-007 Port iload  out  32  fetched instruction word.
REQ-008 Port iwait  out  1  instruction requester must hold.
REQ-009 Port dREN  in  1  data read request.
REQ-010 Port dWEN  in  1  data write request.
REQ-011 Port daddr  in  32  data address.
REQ-012 Port dstore  in  32  write data.
REQ-013 Port dload  out  32  read data.
REQ-014 Port dwait  out  1  data requester must hold.
REQ-015 Port ramREN  out  1  RAM read strobe.
REQ-016 Port ramWEN  out  1  RAM write strobe.
REQ-017 Port ramaddr  out  32  RAM address.
REQ-018 Port ramstore  out  32  RAM write data.
REQ-019 Port ramload  in  32  RAM read data, valid when ramready is high.
REQ-020 Port ramready  in  1  one-cycle completion pulse from the RAM.
REQ-021 Port err  out  1  sticky timeout flag.

Function
REQ-022 The FSM SHALL have three states: IDLE, IACC and DACC.
REQ-023 In IDLE, a pending data request (dREN|dWEN) SHALL go to DACC; otherwise iREN SHALL go to IACC; otherwise the FSM SHALL stay in IDLE.
REQ-024 Starvation override: in IDLE with iREN high and starve count == DMAX, the FSM SHALL go to IACC regardless of data requests.
REQ-025 The starve count SHALL increment (saturating at DMAX) on a DACC grant made while iREN is high, and SHALL clear on an IACC grant or on a DACC grant made with iREN low.
REQ-026 On the grant edge, address, store data and op SHALL be latched; the RAM outputs SHALL be driven only from latched values while in IACC or DACC.
REQ-027 With dREN and dWEN both high, the write SHALL take precedence.
REQ-028 ramREN SHALL be high in IACC and in DACC-read; ramWEN SHALL be high in DACC-write; both SHALL be low in IDLE.
REQ-029 Completion: ramready high in IACC/DACC SHALL return the FSM to IDLE on the next edge.
REQ-030 Completion is a single cycle; there is no back-to-back grant, so one IDLE bubble cycle always separates accesses.
REQ-031 iwait SHALL equal iREN & !(state==IACC & ramready), combinationally.
REQ-032 dwait SHALL equal (dREN|dWEN) & !(state==DACC & ramready), combinationally.
REQ-033 iload and dload SHALL pass ramload combinationally in their respective completion cycle and SHALL be 32'h0 otherwise.
REQ-034 The timeout counter SHALL clear on every grant and SHALL increment each access cycle without ramready.
REQ-035 When the timeout counter reaches TIMEOUT, the FSM SHALL return to IDLE and err SHALL set.
REQ-036 In the timeout cycle, the owner's wait SHALL drop for one cycle and its load SHALL be 32'hFFFFFFFF.
REQ-037 If the requester drops its request mid-access, the RAM access SHALL still complete and its result SHALL be discarded.
REQ-038 A ramready arriving in IDLE SHALL be ignored.

Reset
REQ-039 While RST is high at an edge, the next state SHALL be IDLE, with starve count, timeout counter, latched registers and err all 0.
REQ-040 After a reset edge, including reset mid-access, ramREN, ramWEN, ramaddr and ramstore SHALL be 0 and iwait/dwait SHALL follow the requests.
REQ-041 err SHALL clear only on reset.

Verification
REQ-042 Single fetch: iREN=1, iaddr=0x8, RAM returns 0x8C430003 after 3 cycles -> ramREN high 3 cycles, ramaddr=0x8, iwait low exactly in the ramready cycle, iload=0x8C430003.
REQ-043 Contention: iREN and dWEN asserted together, daddr=0x40, dstore=0xAC240003 -> DACC first with ramWEN=1; IACC follows after a one-cycle IDLE bubble; iwait high throughout.
REQ-044 Starvation: data requests held continuously with iREN high and DMAX=4 -> exactly 4 DACC grants, then one IACC grant, then the starve count is back to 0.
REQ-045 Timeout: dREN=1 with ramready never asserted -> after 15 access cycles dwait drops for one cycle, dload=0xFFFFFFFF, err=1 and remains set until RST.
REQ-046 Reset mid-access: RST pulsed during IACC -> the next cycle is IDLE with ramREN=0 and err=0, and a stale ramready in that cycle does not change state.
